// File: rtl/pipe4.sv
// pipe4: memory-access stage. Registers the execute payload, captures the data-RAM
// read word on the first cycle of occupancy and aligns/extends load data.
// Optional forwarding port enabled by defining PIPE4_FWD_EN.
module pipe4 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,

    input  logic        valid_in,
    output logic        allow_in,
    output logic        valid_out,
    input  logic        allow_out,

    input  logic [5:0]  ex_in,
    output logic [5:0]  ex_out,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_out,
    input  logic [4:0]  dest_in,
    output logic [4:0]  dest_out,
    input  logic [31:0] ctrl_info_in,
    output logic [31:0] ctrl_info_out,
    input  logic [31:0] ctrl_info2_in,
    output logic [31:0] ctrl_info2_out,
    input  logic [31:0] mem_value_in,
    input  logic [1:0]  offset_in,

    input  logic [31:0] data_ram_dout,

    output logic [31:0] wb_value,
    output logic        reg_we_out,
    output logic        fwd_valid,
    output logic [4:0]  fwd_dest,
    output logic [31:0] fwd_value
);

    logic        valid;
    logic        fresh;
    logic        accept;
    logic [31:0] ld_buf;

    logic [5:0]  ex_r;
    logic [31:0] pc_r;
    logic [4:0]  dest_r;
    logic [31:0] ctrl_r;
    logic [31:0] ctrl2_r;
    logic [31:0] mem_value_r;
    logic [1:0]  offset_r;

    logic        reg_we;
    logic        load_op;
    logic [4:0]  load_type;
    logic        no_ex;
    logic [31:0] raw_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] aligned;

    // ready_to_go is constant 1, so the stage drains whenever pipe5 accepts
    assign allow_in  = !valid || allow_out;
    assign valid_out = valid & ~flush;
    assign accept    = valid_in & allow_in & ~flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (allow_in) begin
            valid <= valid_in;
        end
    end

    // RAM data is only valid in the first occupied cycle; hold it for stalls
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fresh  <= 1'b0;
            ld_buf <= '0;
        end else begin
            fresh <= accept;
            if (fresh) begin
                ld_buf <= data_ram_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_r        <= '0;
            pc_r        <= '0;
            dest_r      <= '0;
            ctrl_r      <= '0;
            ctrl2_r     <= '0;
            mem_value_r <= '0;
            offset_r    <= '0;
        end else if (accept) begin
            ex_r        <= ex_in;
            pc_r        <= pc_in;
            dest_r      <= dest_in;
            ctrl_r      <= ctrl_info_in;
            ctrl2_r     <= ctrl_info2_in;
            mem_value_r <= mem_value_in;
            offset_r    <= offset_in;
        end
    end

    assign reg_we    = ctrl_r[27];
    assign load_op   = ctrl_r[11];
    assign load_type = ctrl_r[10:6];
    assign no_ex     = ~|ex_r;
    assign raw_word  = fresh ? data_ram_dout : ld_buf;

    always_comb begin
        ld_byte = raw_word[7:0];
        case (offset_r)
            2'd0:    ld_byte = raw_word[7:0];
            2'd1:    ld_byte = raw_word[15:8];
            2'd2:    ld_byte = raw_word[23:16];
            default: ld_byte = raw_word[31:24];
        endcase
        ld_half = offset_r[1] ? raw_word[31:16] : raw_word[15:0];
    end

    // Zero or multi-hot load_type falls back to the raw word
    always_comb begin
        aligned = raw_word;
        case (load_type)
            5'b00001: aligned = raw_word;
            5'b00010: aligned = {{24{ld_byte[7]}}, ld_byte};
            5'b00100: aligned = {24'd0, ld_byte};
            5'b01000: aligned = {{16{ld_half[15]}}, ld_half};
            5'b10000: aligned = {16'd0, ld_half};
            default:  aligned = raw_word;
        endcase
    end

    assign wb_value   = (load_op & no_ex) ? aligned : mem_value_r;
    assign reg_we_out = reg_we & valid & no_ex;

    assign ex_out         = ex_r;
    assign pc_out         = pc_r;
    assign dest_out       = dest_r;
    assign ctrl_info_out  = ctrl_r;
    assign ctrl_info2_out = ctrl2_r;

`ifdef PIPE4_FWD_EN
    assign fwd_valid = valid & reg_we & no_ex;
    assign fwd_dest  = dest_r;
    assign fwd_value = wb_value;
`else
    assign fwd_valid = 1'b0;
    assign fwd_dest  = '0;
    assign fwd_value = '0;
`endif

endmodule

// File: tb/tb_pipe4.sv
// tb_pipe4: table-driven checks of load alignment/write-back plus directed
// sequences for stall, back-to-back, flush and asynchronous reset.
`timescale 1ns/1ps
module tb_pipe4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        valid_in;
    logic        allow_in;
    logic        valid_out;
    logic        allow_out;
    logic [5:0]  ex_in, ex_out;
    logic [31:0] pc_in, pc_out;
    logic [4:0]  dest_in, dest_out;
    logic [31:0] ctrl_info_in, ctrl_info_out;
    logic [31:0] ctrl_info2_in, ctrl_info2_out;
    logic [31:0] mem_value_in;
    logic [1:0]  offset_in;
    logic [31:0] data_ram_dout;
    logic [31:0] wb_value;
    logic        reg_we_out;
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_value;

    int checks = 0;
    int failures = 0;

    pipe4 dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .valid_in(valid_in), .allow_in(allow_in),
        .valid_out(valid_out), .allow_out(allow_out),
        .ex_in(ex_in), .ex_out(ex_out),
        .pc_in(pc_in), .pc_out(pc_out),
        .dest_in(dest_in), .dest_out(dest_out),
        .ctrl_info_in(ctrl_info_in), .ctrl_info_out(ctrl_info_out),
        .ctrl_info2_in(ctrl_info2_in), .ctrl_info2_out(ctrl_info2_out),
        .mem_value_in(mem_value_in), .offset_in(offset_in),
        .data_ram_dout(data_ram_dout),
        .wb_value(wb_value), .reg_we_out(reg_we_out),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_value(fwd_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lop;
        logic [4:0]  lt;
        logic [1:0]  off;
        logic [31:0] dout;
        logic [31:0] mv;
        logic [5:0]  ex;
        logic [4:0]  dest;
        logic [31:0] exp_wb;
        logic        exp_we;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [31:0] mk_ctrl(logic we, logic lop, logic [4:0] lt);
        return {4'b0, we, 15'b0, lop, lt, 6'b0};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        flush         = 1'b0;
        valid_in      = 1'b0;
        allow_out     = 1'b1;
        ex_in         = '0;
        pc_in         = '0;
        dest_in       = '0;
        ctrl_info_in  = '0;
        ctrl_info2_in = '0;
        mem_value_in  = '0;
        offset_in     = '0;
        data_ram_dout = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        //            lop lt        off  dout          mv            ex     dest exp_wb        we
        vecs[0]  = '{1'b1, 5'b00010, 2'd3, 32'h80112233, 32'h0,        6'd0,  5'd1, 32'hFFFFFF80, 1'b1};
        vecs[1]  = '{1'b1, 5'b00100, 2'd3, 32'h80112233, 32'h0,        6'd0,  5'd2, 32'h00000080, 1'b1};
        vecs[2]  = '{1'b1, 5'b00010, 2'd0, 32'h80112233, 32'h0,        6'd0,  5'd3, 32'h00000033, 1'b1};
        vecs[3]  = '{1'b1, 5'b01000, 2'd2, 32'h80112233, 32'h0,        6'd0,  5'd4, 32'hFFFF8011, 1'b1};
        vecs[4]  = '{1'b1, 5'b10000, 2'd0, 32'hBEEF1234, 32'h0,        6'd0,  5'd6, 32'h00001234, 1'b1};
        vecs[5]  = '{1'b1, 5'b01000, 2'd0, 32'h0000F234, 32'h0,        6'd0,  5'd7, 32'hFFFFF234, 1'b1};
        vecs[6]  = '{1'b1, 5'b00001, 2'd0, 32'hCAFEF00D, 32'h0,        6'd0,  5'd5, 32'hCAFEF00D, 1'b1};
        vecs[7]  = '{1'b0, 5'b00000, 2'd0, 32'hFFFFFFFF, 32'h12345678, 6'd0,  5'd8, 32'h12345678, 1'b1};
        vecs[8]  = '{1'b0, 5'b00000, 2'd0, 32'hFFFFFFFF, 32'h12345678, 6'd1,  5'd9, 32'h12345678, 1'b0};
        vecs[9]  = '{1'b1, 5'b00001, 2'd0, 32'h11111111, 32'hAAAA5555, 6'd2,  5'd10, 32'hAAAA5555, 1'b0};
        vecs[10] = '{1'b1, 5'b00000, 2'd1, 32'h11223344, 32'h0,        6'd0,  5'd11, 32'h11223344, 1'b1};
        vecs[11] = '{1'b1, 5'b00011, 2'd1, 32'h11223344, 32'h0,        6'd0,  5'd12, 32'h11223344, 1'b1};
        vecs[12] = '{1'b1, 5'b00010, 2'd1, 32'h0000FF00, 32'h0,        6'd0,  5'd13, 32'hFFFFFFFF, 1'b1};
        vecs[13] = '{1'b1, 5'b00100, 2'd2, 32'h00AB0000, 32'h0,        6'd0,  5'd14, 32'h000000AB, 1'b1};

        drive_idle();
        resetn = 1'b0;
        #12;
        chk("rst_allow_in",  32'(allow_in),   32'd1);
        chk("rst_valid_out", 32'(valid_out),  32'd0);
        chk("rst_reg_we",    32'(reg_we_out), 32'd0);
        chk("rst_fwd_valid", 32'(fwd_valid),  32'd0);
        chk("rst_wb_value",  wb_value,        32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Table: accept at an edge, RAM word arrives in the following cycle
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            valid_in      = 1'b1;
            allow_out     = 1'b1;
            ctrl_info_in  = mk_ctrl(1'b1, vecs[i].lop, vecs[i].lt);
            offset_in     = vecs[i].off;
            mem_value_in  = vecs[i].mv;
            ex_in         = vecs[i].ex;
            dest_in       = vecs[i].dest;
            pc_in         = 32'h400 + 32'(i) * 4;
            data_ram_dout = 32'h5A5A5A5A;
            @(posedge clk); #1;
            valid_in      = 1'b0;
            data_ram_dout = vecs[i].dout;
            #1;
            chk($sformatf("v%0d_wb_value", i), wb_value, vecs[i].exp_wb);
            chk($sformatf("v%0d_valid_out", i), 32'(valid_out), 32'd1);
            chk($sformatf("v%0d_reg_we", i), 32'(reg_we_out), 32'(vecs[i].exp_we));
            chk($sformatf("v%0d_ex_out", i), 32'(ex_out), 32'(vecs[i].ex));
`ifdef PIPE4_FWD_EN
            chk($sformatf("v%0d_fwd_valid", i), 32'(fwd_valid), 32'(vecs[i].exp_we));
            chk($sformatf("v%0d_fwd_dest", i), 32'(fwd_dest), 32'(vecs[i].dest));
            chk($sformatf("v%0d_fwd_value", i), fwd_value, vecs[i].exp_wb);
`else
            chk($sformatf("v%0d_fwd_valid", i), 32'(fwd_valid), 32'd0);
`endif
        end

        // LHU under a 3-cycle stall with RAM output changing
        @(negedge clk);
        drive_idle();
        valid_in     = 1'b1;
        ctrl_info_in = mk_ctrl(1'b1, 1'b1, 5'b10000);
        offset_in    = 2'd2;
        @(posedge clk); #1;
        valid_in      = 1'b0;
        allow_out     = 1'b0;
        data_ram_dout = 32'hBEEF1234;
        #1;
        chk("stall0_wb", wb_value, 32'h0000BEEF);
        chk("stall0_allow_in", 32'(allow_in), 32'd0);
        for (int c = 1; c < 3; c++) begin
            @(posedge clk); #1;
            data_ram_dout = '0;
            #1;
            chk($sformatf("stall%0d_wb", c), wb_value, 32'h0000BEEF);
            chk($sformatf("stall%0d_allow_in", c), 32'(allow_in), 32'd0);
            chk($sformatf("stall%0d_valid_out", c), 32'(valid_out), 32'd1);
        end
        allow_out = 1'b1;
        #1;
        chk("stall_rel_allow_in", 32'(allow_in), 32'd1);
        chk("stall_rel_wb", wb_value, 32'h0000BEEF);
        @(posedge clk); #1;
        chk("stall_drained", 32'(valid_out), 32'd0);

        // Back-to-back payloads, no bubbles
        @(negedge clk);
        drive_idle();
        valid_in = 1'b1;
        pc_in    = 32'h100;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b%0d_pc", i), pc_out, 32'h100 + 32'(i) * 4);
            chk($sformatf("b2b%0d_valid", i), 32'(valid_out), 32'd1);
            chk($sformatf("b2b%0d_allow_in", i), 32'(allow_in), 32'd1);
            if (i < 3) pc_in = 32'h104 + 32'(i) * 4;
            else valid_in = 1'b0;
        end

        // Back-to-back loads: fresh re-arms on replacement
        @(negedge clk);
        drive_idle();
        valid_in     = 1'b1;
        ctrl_info_in = mk_ctrl(1'b1, 1'b1, 5'b00001);
        @(posedge clk); #1;
        data_ram_dout = 32'h11110001;
        #1;
        chk("ld2_first", wb_value, 32'h11110001);
        @(posedge clk); #1;
        valid_in      = 1'b0;
        data_ram_dout = 32'h22220002;
        #1;
        chk("ld2_second", wb_value, 32'h22220002);

        // Flush with a valid payload and an incoming one
        @(negedge clk);
        drive_idle();
        valid_in     = 1'b1;
        allow_out    = 1'b0;
        ctrl_info_in = mk_ctrl(1'b1, 1'b0, 5'b0);
        pc_in        = 32'h200;
        @(posedge clk); #1;
        chk("fl_pre_valid", 32'(valid_out), 32'd1);
        flush     = 1'b1;
        pc_in     = 32'h300;
        allow_out = 1'b1;
        #1;
        chk("fl_same_cycle", 32'(valid_out), 32'd0);
        @(posedge clk); #1;
        flush    = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("fl_after_valid", 32'(valid_out), 32'd0);
        chk("fl_after_we", 32'(reg_we_out), 32'd0);
        chk("fl_after_allow", 32'(allow_in), 32'd1);

        // Asynchronous reset during a stall
        @(negedge clk);
        drive_idle();
        valid_in     = 1'b1;
        allow_out    = 1'b0;
        ctrl_info_in = mk_ctrl(1'b1, 1'b1, 5'b00001);
        @(posedge clk); #1;
        valid_in      = 1'b0;
        data_ram_dout = 32'hDEADBEEF;
        #1;
        chk("ar_pre_wb", wb_value, 32'hDEADBEEF);
        #1;
        resetn = 1'b0;
        #1;
        chk("ar_valid_out", 32'(valid_out), 32'd0);
        chk("ar_allow_in", 32'(allow_in), 32'd1);
        chk("ar_wb_value", wb_value, 32'd0);
        chk("ar_reg_we", 32'(reg_we_out), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("ar_post_valid", 32'(valid_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe4.md
# pipe4

Memory-access stage of the 5-stage MIPS pipeline, directly downstream of the execute stage (pipe3). It registers the execute-stage payload and captures the synchronous data-RAM read word in the first cycle of occupancy. It aligns and extends load data, then presents the write-back value, exception vector and forwarding info to the write-back stage (pipe5) through the standard valid/allow handshake.

## Interface
Parameters: none.
- clk  in  1  pipeline clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  exception/eret flush from write-back; kills the stage content
- valid_in  in  1  pipe3 payload valid (pipe3 `valid_out`)
- allow_in  out  1  stage can accept a payload this cycle
- valid_out  out  1  payload ready for pipe5
- allow_out  in  1  pipe5 can accept
- ex_in / ex_out  in/out  6  exception code {ov,3'b0,ades,adel} or upstream code
- pc_in / pc_out  in/out  32  instruction PC
- dest_in / dest_out  in/out  5  destination GPR
- ctrl_info_in / ctrl_info_out  in/out  32  control word; [27] reg_we, [11] load_op, [10:6] load_type
- ctrl_info2_in / ctrl_info2_out  in/out  32  second control word, passed through
- mem_value_in  in  32  ALU/MT result from pipe3
- offset_in  in  2  byte offset of data address
- data_ram_dout  in  32  synchronous RAM read data, valid only in the cycle after the address was issued
- wb_value  out  32  value for GPR/HI/LO/CP0 write
- reg_we_out  out  1  ctrl_info[27] & valid & ~|ex
- fwd_valid  out  1  forwarding value valid (see Configuration)
- fwd_dest  out  5  forwarding destination
- fwd_value  out  32  forwarding value (= wb_value)

## Operation
- ready_to_go = 1. allow_in = !valid || allow_out. valid_out = valid & ~flush.
- Transfer in: at the clock edge where allow_in is high, valid <= valid_in & ~flush. Payload registers load only when valid_in & allow_in.
- Load capture: the `fresh` flag is set on each transfer-in and cleared on the next edge. While fresh, the raw word is data_ram_dout, and ld_buf <= data_ram_dout. Otherwise the raw word is ld_buf. Stalls of any length therefore preserve the load data.
- load_type one-hot: [0] LW, [1] LB, [2] LBU, [3] LH, [4] LHU.
  - LB/LBU: byte = raw[8*offset+:8], sign- or zero-extended.
  - LH/LHU: half = raw[16*offset[1]+:16], sign- or zero-extended.
  - LW: raw.
  - Zero or non-one-hot load_type: raw.
- wb_value = (load_op & ~|ex) ? aligned : mem_value.
- ex_out, pc_out, dest_out and both control words pass through from registers.
- Flush has priority over everything: valid clears at the next edge, and an incoming payload in the same cycle is dropped.

## Timing
- Reset values: valid=0, fresh=0, ld_buf=0, all payload registers 0. Resulting outputs: allow_in=1, valid_out=0, reg_we_out=0, fwd_valid=0, wb_value=0.
- Latency: payload accepted at edge N appears on the outputs in cycle N+1. The load value is combinational from data_ram_dout in that cycle.
- Back-pressure: with allow_out=0 and valid=1, all outputs hold, allow_in=0, and data_ram_dout is ignored after the first cycle.
- Simultaneous transfer-out and transfer-in: the new payload replaces the old one at the same edge, and fresh is set again.
- resetn asserted mid-stall: state clears immediately (asynchronous). No partial payload survives.

## Configuration
- PIPE4_FWD_EN defined:
  - fwd_valid = valid & reg_we & ~|ex.
  - fwd_dest = dest.
  - fwd_value = wb_value, including the aligned load data.
  - The decode stage may bypass from this stage.
- PIPE4_FWD_EN undefined: fwd_valid, fwd_dest and fwd_value are tied to 0, and decode must stall on pipe4 hazards.

## Test plan
- LB at offset 3, data_ram_dout=0x80_11_22_33, allow_out=1 -> next cycle wb_value=0xFFFFFF80, valid_out=1, reg_we_out=1.
- LHU at offset 2, dout=0xBEEF1234; allow_out=0 for 3 cycles, and dout changes to 0 after the first cycle -> wb_value stays 0x0000BEEF throughout, allow_in=0; released on allow_out=1.
- Non-load, mem_value_in=0x12345678, ex_in=0 -> wb_value=0x12345678. Same case with ex_in=6'b000001 (adel) -> reg_we_out=0, ex_out=0x01.
- Back-to-back valid_in with allow_out=1 for 4 cycles with PCs 0x100/0x104/0x108/0x10C -> pc_out follows one cycle later, no bubbles, allow_in=1 throughout.
- flush=1 while valid=1 and valid_in=1 -> valid_out=0 in that cycle, valid=0 after the edge, incoming payload dropped.
- With PIPE4_FWD_EN: LW dest=5, dout=0xCAFEF00D -> fwd_valid=1, fwd_dest=5, fwd_value=0xCAFEF00D. Without PIPE4_FWD_EN: fwd_valid=0 for the same stimulus.
